// File: rtl/sb_config_loader.sv
// ---------------------------------------------------------------------------
// sb_config_loader
//   Serial configuration controller for a daisy chain of NUM_SB switchboxes.
//   Accepts the routing bitstream as WORD_W-bit words over a valid/ready
//   stream and shifts it MSB-first into the chain. It can then optionally
//   verify the load. Verify recirculates the whole chain once (cfg_dout is
//   fed from cfg_din) and compares the CRC-16 of the returned bits against
//   the CRC-16 of the loaded bits.
//
//   Handshake: a word transfers on a rising clk edge where word_valid and
//   word_ready are both 1. word_ready is only high in WAIT_WORD. The
//   producer may raise or drop word_valid at any time.
//
// Ports
//   clk, nrst            clock, asynchronous active-low reset
//   start, verify_en     begin a run (ignored while busy); verify_en is
//                        sampled with start
//   abort                drop back to IDLE from any busy state, no done
//   word_valid/ready     input word stream, word_data bit WORD_W-1 first
//   cfg_en, cfg_dout     shift enable and serial data to the first SB
//   cfg_din              serial data back from the last SB
//   busy, done, pass     status; done is a 1-cycle pulse
//   crc_out              CRC-16 of the loaded bitstream
//   dbg_state            current FSM state, for observation only
// ---------------------------------------------------------------------------
module sb_config_loader #(
   parameter int NUM_SB   = 4,
   parameter int SB_WIDTH = 32,
   parameter int WORD_W   = 32
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic              verify_en,
   input  logic              abort,
   input  logic              word_valid,
   input  logic [WORD_W-1:0] word_data,
   output logic              word_ready,
   output logic              cfg_en,
   output logic              cfg_dout,
   input  logic              cfg_din,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       crc_out,
   output logic [2:0]        dbg_state
);

   localparam int TOTAL_BITS = NUM_SB * SB_WIDTH * 8;
   localparam int NUM_WORDS  = TOTAL_BITS / WORD_W;
   localparam int BIT_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int WC_W       = $clog2(NUM_WORDS + 1);
   localparam int VC_W       = $clog2(TOTAL_BITS + 1);

   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);
   localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(NUM_WORDS - 1);
   localparam logic [VC_W-1:0]  LAST_VBIT = VC_W'(TOTAL_BITS - 1);
   localparam logic [15:0]      CRC_INIT  = 16'hFFFF;
   localparam logic [15:0]      CRC_POLY  = 16'h1021;

   if ((TOTAL_BITS % WORD_W) != 0) begin : g_bad_cfg
      $error("sb_config_loader: TOTAL_BITS must be a multiple of WORD_W");
   end

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_WORD = 3'd1,
      S_SHIFT     = 3'd2,
      S_VERIFY    = 3'd3,
      S_FINISH    = 3'd4
   } state_t;

   state_t            r_state;
   logic [WORD_W-1:0] r_shreg;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic [WC_W-1:0]   r_word_cnt;
   logic [VC_W-1:0]   r_vcnt;
   logic [15:0]       r_crc;
   logic [15:0]       r_crc_out;
   logic              r_verify;
   logic              r_word_ready;
   logic              r_cfg_en;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;

   logic              w_bit;
   logic              w_fb;
   logic [15:0]       w_crc_next;

   // Bit on the chain input this cycle: the shift register while loading,
   // the chain's own output while recirculating. Gated so the line is quiet
   // whenever the chain is not shifting.
   assign w_bit      = (r_state == S_VERIFY) ? cfg_din : r_shreg[WORD_W-1];
   assign w_fb       = r_crc[15] ^ w_bit;
   assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_fb ? CRC_POLY : 16'h0000);

   assign cfg_dout   = r_cfg_en & w_bit;
   assign word_ready = r_word_ready;
   assign cfg_en     = r_cfg_en;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign crc_out    = r_crc_out;
   assign dbg_state  = r_state;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state      <= S_IDLE;
         r_shreg      <= '0;
         r_bit_cnt    <= '0;
         r_word_cnt   <= '0;
         r_vcnt       <= '0;
         r_crc        <= CRC_INIT;
         r_crc_out    <= '0;
         r_verify     <= 1'b0;
         r_word_ready <= 1'b0;
         r_cfg_en     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (abort && (r_state != S_IDLE)) begin
            r_state      <= S_IDLE;
            r_word_ready <= 1'b0;
            r_cfg_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_pass       <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start && !abort) begin
                     r_state      <= S_WAIT_WORD;
                     r_verify     <= verify_en;
                     r_word_cnt   <= '0;
                     r_crc        <= CRC_INIT;
                     r_pass       <= 1'b0;
                     r_busy       <= 1'b1;
                     r_word_ready <= 1'b1;
                  end
               end
               S_WAIT_WORD: begin
                  if (word_valid) begin
                     r_state      <= S_SHIFT;
                     r_shreg      <= word_data;
                     r_bit_cnt    <= '0;
                     r_word_ready <= 1'b0;
                     r_cfg_en     <= 1'b1;
                  end
               end
               S_SHIFT: begin
                  r_crc     <= w_crc_next;
                  r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == LAST_BIT) begin
                     r_bit_cnt  <= '0;
                     r_word_cnt <= r_word_cnt + 1'b1;
                     if (r_word_cnt == LAST_WORD) begin
                        // Load complete: publish the CRC and restart it for
                        // the returned stream.
                        r_crc_out <= w_crc_next;
                        r_crc     <= CRC_INIT;
                        if (r_verify) begin
                           r_state <= S_VERIFY;
                           r_vcnt  <= '0;
                        end else begin
                           r_state  <= S_FINISH;
                           r_cfg_en <= 1'b0;
                           r_done   <= 1'b1;
                           r_pass   <= 1'b1;
                        end
                     end else begin
                        r_state      <= S_WAIT_WORD;
                        r_cfg_en     <= 1'b0;
                        r_word_ready <= 1'b1;
                     end
                  end
               end
               S_VERIFY: begin
                  r_crc  <= w_crc_next;
                  r_vcnt <= r_vcnt + 1'b1;
                  if (r_vcnt == LAST_VBIT) begin
                     // Compare using the CRC including this final bit.
                     r_state  <= S_FINISH;
                     r_cfg_en <= 1'b0;
                     r_done   <= 1'b1;
                     r_pass   <= (w_crc_next == r_crc_out);
                  end
               end
               S_FINISH: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state      <= S_IDLE;
                  r_word_ready <= 1'b0;
                  r_cfg_en     <= 1'b0;
                  r_busy       <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sb_config_loader.sv
// ---------------------------------------------------------------------------
// tb_sb_config_loader
//   Bench for sb_config_loader with a one-switchbox chain (32 config bits,
//   16-bit words). A behavioural 32-bit chain model sits on cfg_en/cfg_dout/
//   cfg_din. Expected results {chain, cfg_en cycles, pass, crc_out} are
//   queued when a run is issued and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_sb_config_loader;

   localparam int NUM_SB   = 1;
   localparam int SB_WIDTH = 4;
   localparam int WORD_W   = 16;
   localparam int EXP_W    = 58;

   logic              clk = 1'b0;
   logic              nrst = 1'b0;
   logic              start = 1'b0;
   logic              verify_en = 1'b0;
   logic              abort = 1'b0;
   logic              word_valid = 1'b0;
   logic [WORD_W-1:0] word_data = '0;
   logic              word_ready;
   logic              cfg_en;
   logic              cfg_dout;
   logic              cfg_din;
   logic              busy;
   logic              done;
   logic              pass;
   logic [15:0]       crc_out;
   logic [2:0]        dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int done_seen = 0;

   logic [EXP_W-1:0] exp_q[$];

   // Chain model: 32 bits, MSB is the end of the chain.
   logic [31:0] chain = 32'h0;
   logic        flip_req = 1'b0;

   sb_config_loader #(
      .NUM_SB  (NUM_SB),
      .SB_WIDTH(SB_WIDTH),
      .WORD_W  (WORD_W)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .start     (start),
      .verify_en (verify_en),
      .abort     (abort),
      .word_valid(word_valid),
      .word_data (word_data),
      .word_ready(word_ready),
      .cfg_en    (cfg_en),
      .cfg_dout  (cfg_dout),
      .cfg_din   (cfg_din),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .crc_out   (crc_out),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   assign cfg_din = chain[31];

   always @(posedge clk) begin
      if (cfg_en)
         chain <= {chain[30:0], cfg_dout} ^ (flip_req ? 32'h0000_0100 : 32'h0);
   end

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [15:0] ref_crc(input logic [31:0] bits);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 31; i >= 0; i--) begin
         fb = c[15] ^ bits[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   task automatic push_exp(input logic v, input logic [31:0] stream, input logic flip);
      logic [7:0] en_cycles;
      en_cycles = v ? 8'd64 : 8'd32;
      exp_q.push_back({~flip, stream, en_cycles, ~flip, ref_crc(stream)});
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic       prev_en = 1'b0;
   logic       prev_done = 1'b0;
   logic [7:0] en_cnt = 8'd0;

   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (done) begin
         done_seen++;
         check("done_after_shift", {63'd0, prev_en}, 64'd1);
         check("done_width", {63'd0, prev_done}, 64'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done actual=1 expected=0");
         end else begin
            e = exp_q.pop_front();
            check("pass", {63'd0, pass}, {63'd0, e[16]});
            check("crc_out", {48'd0, crc_out}, {48'd0, e[15:0]});
            check("en_cycles", {56'd0, en_cnt}, {56'd0, e[24:17]});
            if (e[57])
               check("chain", {32'd0, chain}, {32'd0, e[56:25]});
         end
      end
      if (!cfg_en)
         check("dout_idle", {63'd0, cfg_dout}, 64'd0);
      if (!busy)
         en_cnt = 8'd0;
      else if (cfg_en)
         en_cnt = en_cnt + 8'd1;
      prev_en   = cfg_en;
      prev_done = done;
   end

   // ---------------- driver tasks ----------------
   task automatic do_start(input logic v);
      @(negedge clk);
      start     = 1'b1;
      verify_en = v;
      @(negedge clk);
      start     = 1'b0;
      verify_en = 1'b0;
   endtask

   task automatic send_word(input logic [WORD_W-1:0] d, input int gap);
      int k;
      k = 0;
      while (!word_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("ready_timeout", {63'd0, word_ready}, 64'd1);
      for (int g = 0; g < gap; g++) begin
         check("en_low_in_gap", {63'd0, cfg_en}, 64'd0);
         @(negedge clk);
      end
      word_valid = 1'b1;
      word_data  = d;
      @(negedge clk);
      word_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", {63'd0, busy}, 64'd0);
      @(negedge clk);
   endtask

   task automatic run_load(input logic v, input logic [15:0] w0, input logic [15:0] w1,
                           input int gap, input logic flip, input logic mid_start);
      push_exp(v, {w0, w1}, flip);
      do_start(v);
      send_word(w0, gap);
      if (mid_start) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      send_word(w1, gap);
      if (flip) begin
         repeat (20) @(negedge clk);
         flip_req = 1'b1;
         @(negedge clk);
         flip_req = 1'b0;
      end
      wait_idle();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_word_ready"}, {63'd0, word_ready}, 64'd0);
      check({tag, "_cfg_en"}, {63'd0, cfg_en}, 64'd0);
      check({tag, "_cfg_dout"}, {63'd0, cfg_dout}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_done"}, {63'd0, done}, 64'd0);
      check({tag, "_pass"}, {63'd0, pass}, 64'd0);
      check({tag, "_crc_out"}, {48'd0, crc_out}, 64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int ds;
      // reset
      #3;
      check_all_zero("reset");
      check("reset_state", {61'd0, dbg_state}, 64'd0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      // 1: verify, back-to-back words
      run_load(1'b1, 16'hA5C3, 16'h0F0F, 0, 1'b0, 1'b0);
      // 2: same data, 5-cycle gaps
      run_load(1'b1, 16'hA5C3, 16'h0F0F, 5, 1'b0, 1'b0);
      // 3: corrupted chain during verify
      run_load(1'b1, 16'hA5C3, 16'h0F0F, 0, 1'b1, 1'b0);

      // abort and start together in IDLE: stays idle
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort_wins_busy", {63'd0, busy}, 64'd0);

      // 4: abort on the 7th shift cycle of word 0
      ds = done_seen;
      do_start(1'b1);
      send_word(16'h1234, 0);
      repeat (6) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_cfg_en", {63'd0, cfg_en}, 64'd0);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_pass", {63'd0, pass}, 64'd0);
      check("abort_ready", {63'd0, word_ready}, 64'd0);
      repeat (40) @(negedge clk);
      check("abort_no_done", 64'(done_seen), 64'(ds));
      run_load(1'b1, 16'hBEEF, 16'h0001, 1, 1'b0, 1'b0);

      // 5: no verify, start pulsed mid-load
      run_load(1'b0, 16'hA5C3, 16'h0F0F, 0, 1'b0, 1'b1);

      // 6: reset mid-verify
      do_start(1'b1);
      send_word(16'hC0DE, 0);
      send_word(16'hFACE, 0);
      repeat (20) @(negedge clk);
      #2;
      nrst = 1'b0;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      nrst = 1'b1;
      #1;
      check("post_rst_busy", {63'd0, busy}, 64'd0);
      run_load(1'b1, 16'h5A5A, 16'h9C3E, 0, 1'b0, 1'b0);

      // randomized runs
      for (int r = 0; r < 10; r++) begin
         run_load(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 3), 1'b0, 1'b0);
      end

      repeat (5) @(negedge clk);
      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
